// File: rtl/aic3204_i2s_tx_if.sv
// Sample stream from the output FIFO into the AIC3204 I2S transmitter.
// Left channel sits in the upper half of s_data, right channel in the lower half.
interface aic3204_i2s_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [2*SAMPLE_W-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/aic3204_i2s_tx.sv
// I2S bus-master transmitter for the AIC3204 DAC path.
// Divides clk into BCLK/WCLK, latches one stereo sample per frame out of a
// one-entry holding register and shifts it MSB first onto DIN.
// Every codec-facing output is a flop fed from the current divider/bit
// position, so the pins trail the internal counters by one clk.
module aic3204_i2s_tx #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  aic3204_i2s_tx_if.slave s_if,
  input  logic            underrun_clr,
  output logic            bclk_o,
  output logic            wclk_o,
  output logic            din_o,
  output logic            frame_start,
  output logic            underrun
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int IDX_W   = $clog2(FRAME_W);
  localparam int DIV_N   = 2 * BCLK_HALF;
  localparam int DIV_W   = $clog2(DIV_N);
  localparam int BIT_N   = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(BIT_N);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_N - 1);

  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_b;
  logic               r_hold_full;
  logic [FRAME_W-1:0] r_hold_data;
  logic               r_pop;
  logic [FRAME_W-1:0] r_frame;
  logic               r_underrun;
  logic               r_bclk;
  logic               r_wclk;
  logic               r_din;
  logic               r_frame_start;

  logic               w_bnd;
  logic [FRAME_W-1:0] w_load;
  logic [FRAME_W-1:0] w_frame_cur;
  logic [IDX_W-1:0]   w_idx;
  logic               w_din_nxt;
  logic               w_wclk_nxt;
  logic               w_bclk_nxt;

  // Counters sit at zero while disabled, so the first enabled cycle and every
  // wrap back to position zero are both frame boundaries.
  assign w_bnd       = enable && (r_div == '0) && (r_b == '0);
  assign w_load      = r_hold_full ? r_hold_data : '0;
  assign w_frame_cur = w_bnd ? w_load : r_frame;

  // Decode the pin levels for the current bit position.
  always_comb begin
    w_idx      = '0;
    w_din_nxt  = 1'b0;
    w_bclk_nxt = (int'(r_div) >= BCLK_HALF);
    w_wclk_nxt = (int'(r_b) >= SLOT_W - 1) && (int'(r_b) <= 2 * SLOT_W - 2);
    if (int'(r_b) < SAMPLE_W) begin
      w_idx     = IDX_W'(FRAME_W - 1 - int'(r_b));
      w_din_nxt = w_frame_cur[w_idx];
    end else if ((int'(r_b) >= SLOT_W) && (int'(r_b) < SLOT_W + SAMPLE_W)) begin
      w_idx     = IDX_W'(SAMPLE_W - 1 - (int'(r_b) - SLOT_W));
      w_din_nxt = w_frame_cur[w_idx];
    end
  end

  // BCLK divider and bit-within-frame counter; both park at zero when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_b   <= '0;
    end else if (!enable) begin
      r_div <= '0;
      r_b   <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_b   <= (r_b == BIT_LAST) ? '0 : r_b + BIT_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Holding register; the pop lands one cycle after the boundary so s_ready
  // stays low through the frame_start cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_pop       <= 1'b0;
    end else begin
      r_pop <= w_bnd && r_hold_full;
      if (r_pop) begin
        r_hold_full <= 1'b0;
      end else if (s_if.s_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= s_if.s_data;
      end
    end
  end

  // Frame register: captured at each boundary, dropped when the bus is parked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
    end else if (!enable) begin
      r_frame <= '0;
    end else if (w_bnd) begin
      r_frame <= w_load;
    end
  end

  // Sticky underrun; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_bnd && !r_hold_full) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  // Registered codec pins and frame marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk        <= 1'b0;
      r_wclk        <= 1'b0;
      r_din         <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_bclk        <= 1'b0;
      r_wclk        <= 1'b0;
      r_din         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_bclk        <= w_bclk_nxt;
      r_wclk        <= w_wclk_nxt;
      r_din         <= w_din_nxt;
      r_frame_start <= w_bnd;
    end
  end

  assign s_if.s_ready = ~r_hold_full;
  assign bclk_o       = r_bclk;
  assign wclk_o       = r_wclk;
  assign din_o        = r_din;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_aic3204_i2s_tx.sv
// Directed bench for aic3204_i2s_tx: default instance plus a 24/24/2 instance.
module tb_aic3204_i2s_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic en_b = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  logic bclk_a, wclk_a, din_a, fs_a, ur_a;
  logic bclk_b, wclk_b, din_b, fs_b, ur_b;

  aic3204_i2s_tx_if #(.SAMPLE_W(16)) if_a ();
  aic3204_i2s_tx_if #(.SAMPLE_W(24)) if_b ();

  aic3204_i2s_tx #(.SAMPLE_W(16), .SLOT_W(32), .BCLK_HALF(4)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s_if(if_a),
    .underrun_clr(clr_a), .bclk_o(bclk_a), .wclk_o(wclk_a), .din_o(din_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  aic3204_i2s_tx #(.SAMPLE_W(24), .SLOT_W(24), .BCLK_HALF(2)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .s_if(if_b),
    .underrun_clr(clr_b), .bclk_o(bclk_b), .wclk_o(wclk_b), .din_o(din_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit src_on = 1'b0;
  int src_n = 0;

  localparam logic [63:0] WV_A = 64'h0000_0001_FFFF_FFFE;
  localparam logic [63:0] WV_B = 64'h0000_0000_01FF_FFFE;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int n);
    logic [15:0] v;
    v = 16'(n);
    return {v, v ^ 16'hFFFF};
  endfunction

  function automatic logic [63:0] exp_a(input logic [31:0] s);
    return {s[31:16], 16'h0000, s[15:0], 16'h0000};
  endfunction

  // One clk; the source offers the next incrementing sample after each accept.
  task automatic step();
    logic acc;
    acc = src_on && if_a.s_valid && if_a.s_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      src_n++;
      if_a.s_data = mk(src_n);
    end
  endtask

  // Sample DIN/WCLK on every BCLK rising edge for ncyc clocks.
  task automatic collect(input bit sel_b, input int ncyc,
                         output logic [63:0] dv, output logic [63:0] wv,
                         output int fs_cnt, output int rdy_cnt, output int nedge);
    logic prev, bc, dn, wc, fs, rd;
    dv = '0; wv = '0; fs_cnt = 0; rdy_cnt = 0; nedge = 0; prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bc = sel_b ? bclk_b : bclk_a;
      dn = sel_b ? din_b : din_a;
      wc = sel_b ? wclk_b : wclk_a;
      fs = sel_b ? fs_b : fs_a;
      rd = sel_b ? if_b.s_ready : if_a.s_ready;
      if (bc && !prev) begin
        dv = {dv[62:0], dn};
        wv = {wv[62:0], wc};
        nedge++;
      end
      prev = bc;
      if (fs) fs_cnt++;
      if (rd) rdy_cnt++;
      step();
    end
  endtask

  initial begin
    logic [63:0] dv, wv;
    int fs_cnt, rdy_cnt, nedge;

    if_a.s_data = '0; if_a.s_valid = 1'b0;
    if_b.s_data = '0; if_b.s_valid = 1'b0;

    // power-on reset, observed without any clock edge
    #1 reset_n = 1'b0;
    #1;
    check("rst_bclk", 64'(bclk_a), 64'd0);
    check("rst_wclk", 64'(wclk_a), 64'd0);
    check("rst_din", 64'(din_a), 64'd0);
    check("rst_fs", 64'(fs_a), 64'd0);
    check("rst_ur", 64'(ur_a), 64'd0);
    check("rst_ready", 64'(if_a.s_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // single frame {A5F0, 0F5A}
    if_a.s_data = 32'hA5F0_0F5A; if_a.s_valid = 1'b1;
    step();
    if_a.s_valid = 1'b0;
    check("hold_full_ready", 64'(if_a.s_ready), 64'd0);
    enable = 1'b1;
    step();
    check("first_fs", 64'(fs_a), 64'd1);
    check("first_fs_ready", 64'(if_a.s_ready), 64'd0);
    check("first_ur", 64'(ur_a), 64'd0);
    check("first_msb", 64'(din_a), 64'd1);
    collect(1'b0, 512, dv, wv, fs_cnt, rdy_cnt, nedge);
    check("frame1_din", dv, exp_a(32'hA5F0_0F5A));
    check("frame1_wclk", wv, WV_A);
    check("frame1_edges", 64'(nedge), 64'd64);
    check("frame1_fs_cnt", 64'(fs_cnt), 64'd1);

    // empty hold at the next boundary
    check("frame2_fs", 64'(fs_a), 64'd1);
    check("frame2_ur", 64'(ur_a), 64'd1);
    collect(1'b0, 512, dv, wv, fs_cnt, rdy_cnt, nedge);
    check("frame2_din_zero", dv, 64'd0);
    check("frame2_ur_hold", 64'(ur_a), 64'd1);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("ur_cleared", 64'(ur_a), 64'd0);
    repeat (510) step();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("clr_vs_set_fs", 64'(fs_a), 64'd1);
    check("clr_vs_set_ur", 64'(ur_a), 64'd1);

    // park, clear, then stream 1,2,3
    enable = 1'b0;
    step();
    check("park_bclk", 64'(bclk_a), 64'd0);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    src_on = 1'b1; src_n = 1;
    if_a.s_data = mk(1); if_a.s_valid = 1'b1;
    step();
    enable = 1'b1;
    step();
    check("stream_fs0", 64'(fs_a), 64'd1);
    check("stream_ready0", 64'(if_a.s_ready), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      collect(1'b0, 512, dv, wv, fs_cnt, rdy_cnt, nedge);
      check($sformatf("stream%0d_din", k), dv, exp_a(mk(k)));
      check($sformatf("stream%0d_fs_cnt", k), 64'(fs_cnt), 64'd1);
      check($sformatf("stream%0d_rdy_cnt", k), 64'(rdy_cnt), 64'd1);
      check($sformatf("stream%0d_next_fs", k), 64'(fs_a), 64'd1);
      check($sformatf("stream%0d_ur", k), 64'(ur_a), 64'd0);
    end

    // let sample 5 into hold, then drop enable around b=20
    step();
    step();
    if_a.s_valid = 1'b0; src_on = 1'b0;
    repeat (157) step();
    check("pre_drop_bclk", 64'(bclk_a), 64'd1);
    enable = 1'b0;
    step();
    check("drop_bclk", 64'(bclk_a), 64'd0);
    check("drop_wclk", 64'(wclk_a), 64'd0);
    check("drop_din", 64'(din_a), 64'd0);
    repeat (5) step();
    check("drop_hold_kept", 64'(if_a.s_ready), 64'd0);
    enable = 1'b1;
    step();
    check("reen_fs", 64'(fs_a), 64'd1);
    collect(1'b0, 512, dv, wv, fs_cnt, rdy_cnt, nedge);
    check("reen_din", dv, exp_a(mk(5)));
    check("reen_ur", 64'(ur_a), 64'd1);

    // 24-bit samples in 24-bit slots, 4 clk per bit
    if_b.s_data = 48'h800001_7FFFFE; if_b.s_valid = 1'b1;
    step();
    if_b.s_valid = 1'b0;
    check("b_ready_low", 64'(if_b.s_ready), 64'd0);
    en_b = 1'b1;
    step();
    check("b_fs", 64'(fs_b), 64'd1);
    collect(1'b1, 192, dv, wv, fs_cnt, rdy_cnt, nedge);
    check("b_din", dv, {16'h0000, 24'h800001, 24'h7FFFFE});
    check("b_wclk", wv, WV_B);
    check("b_edges", 64'(nedge), 64'd48);
    check("b_fs_cnt", 64'(fs_cnt), 64'd1);
    check("b_next_fs", 64'(fs_b), 64'd1);
    check("b_ur", 64'(ur_b), 64'd1);

    // asynchronous reset in the middle of a frame with hold full
    if_a.s_data = mk(9); if_a.s_valid = 1'b1;
    step();
    if_a.s_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_ready", 64'(if_a.s_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bclk", 64'(bclk_a), 64'd0);
    check("mid_rst_wclk", 64'(wclk_a), 64'd0);
    check("mid_rst_din", 64'(din_a), 64'd0);
    check("mid_rst_fs", 64'(fs_a), 64'd0);
    check("mid_rst_ur", 64'(ur_a), 64'd0);
    check("mid_rst_ready", 64'(if_a.s_ready), 64'd1);
    check("mid_rst_ur_b", 64'(ur_b), 64'd0);
    check("mid_rst_bclk_b", 64'(bclk_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aic3204_i2s_tx.md
Name: aic3204_i2s_tx

Overview:
- I2S bus-master transmitter for the AIC3204 DAC path.
- Generates BCLK and WCLK from the fabric clock and serialises stereo samples onto the codec DIN pin.
- Samples arrive from an output FIFO on a valid/ready stream and pass through a one-entry holding register.
- Raises a sticky underrun flag when no sample is ready at a frame boundary.

Parameters:
- SAMPLE_W, 16: bits per channel sample, sent MSB first.
- SLOT_W, 32: BCLK periods per channel slot; must be at least SAMPLE_W.
- BCLK_HALF, 4: clk cycles per BCLK half-period; minimum 2.

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run the bus; low parks it idle.
- s_data  in  2*SAMPLE_W  stereo sample; left in the upper half, right in the lower half.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  the holding register is empty and can accept.
- underrun_clr  in  1  single-cycle pulse that clears underrun.
- bclk_o  out  1  bit clock to the codec.
- wclk_o  out  1  word clock: low = left slot, high = right slot.
- din_o  out  1  serial data to the codec.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- underrun  out  1  sticky flag: a frame started with an empty holding register.

Behaviour:
- Reset state (reset_n low, async): bclk_o, wclk_o, din_o, frame_start and underrun are 0. Holding register is empty, so s_ready=1. All counters are 0.
- All outputs are registered. There is no combinational path from input to output.
- Holding register:
  - s_ready is the inverse of the hold-full flag.
  - A transfer occurs when s_valid && s_ready; the register becomes full on the next clk.
  - Holding and s_ready behave the same whether enable is high or low.
- Divider: div counts 0..2*BCLK_HALF-1 and wraps.
  - bclk_o=0 for div<BCLK_HALF, 1 otherwise.
  - A "bit tick" occurs when div wraps to 0, which is the BCLK falling edge.
- Bit counter: b counts 0..2*SLOT_W-1 and advances on each bit tick, wrapping to 0.
  - A frame boundary is b reaching 0.
  - The cycle in which enable first goes high is also a frame boundary, with div=0 and b=0.
- At each frame boundary:
  - If hold is full: the frame register loads from hold and hold empties. s_ready returns to 1 on the next cycle.
  - If hold is empty: the frame register loads 0 and underrun is set.
  - frame_start pulses for that one cycle.
- din_o (I2S format, 1-BCLK delay, changes on the BCLK falling edge, codec samples on the rising edge):
  - b < SAMPLE_W: left[SAMPLE_W-1-b].
  - SLOT_W <= b < SLOT_W+SAMPLE_W: right[SAMPLE_W-1-(b-SLOT_W)].
  - All other b: 0.
- wclk_o:
  - 1 for SLOT_W-1 <= b <= 2*SLOT_W-2; 0 otherwise.
  - WCLK therefore transitions one BCLK before each slot's MSB.
- underrun_clr clears underrun. If the clear coincides with a set, the set wins.
- enable low:
  - Within one cycle, bclk_o, wclk_o and din_o drive 0 and div/b reset to 0.
  - The frame register is discarded. Hold and underrun are retained.
  - Re-enable begins a fresh frame at b=0.
- Reset mid-frame: all state clears asynchronously. Any sample in hold is lost.
- Timing: frame length is 2*SLOT_W*2*BCLK_HALF clk cycles (512 at defaults).
- Latency: from a sample accepted into hold to its left MSB on din_o is at most one frame plus one cycle.

Test Plan:
- Reset check: assert reset_n=0 mid-run -> bclk_o=wclk_o=din_o=underrun=frame_start=0 and s_ready=1 immediately, with no clk edge needed.
- Single frame, defaults: push {0xA5F0,0x0F5A}, then enable=1.
  - Sampling din_o on bclk_o rising edges gives left bits 1010010111110000 followed by 16 zeros while wclk_o=0.
  - Right bits 0000111101011010 follow, then 16 zeros, while wclk_o=1.
  - wclk_o rises 1 BCLK before the right MSB.
- Streaming: source holds s_valid=1 with incrementing samples 1,2,3.
  - frame_start pulses every 512 clk.
  - s_ready is low from each accept until the cycle after the following frame_start.
  - Every transmitted frame carries the next value; no underrun.
- Underrun: enable with hold empty -> din_o all 0 for the frame and underrun=1.
  - An underrun_clr pulse clears it.
  - underrun_clr coincident with a boundary that has an empty hold -> underrun stays 1.
- Enable drop: deassert enable at b=20 -> bclk_o/wclk_o/din_o are 0 the next cycle and the held sample is retained.
  - Re-enable -> frame_start fires that cycle and the retained sample is transmitted.
- Parameters SAMPLE_W=24, SLOT_W=24, BCLK_HALF=2: push {0x800001,0x7FFFFE} -> frame length is 192 clk and no zero padding appears.
